// File: rtl/perceptron_layer_seq_if.sv
// Pixel/target/learn request, weight write port and classification result bundle.
// master drives requests and weight writes; slave is the perceptron layer.
interface perceptron_layer_seq_if #(
    parameter int N_IN      = 20,
    parameter int N_OUT     = 8,
    parameter int W_WIDTH   = 16,
    parameter int ACC_WIDTH = 32
);
    localparam int IW = $clog2(N_IN);
    localparam int JW = $clog2(N_OUT);

    logic                         in_valid;
    logic                         in_ready;
    logic [N_IN-1:0]              letter;
    logic                         learn;
    logic [N_OUT-1:0]             target;
    logic                         w_wr;
    logic [IW-1:0]                w_i;
    logic [JW-1:0]                w_j;
    logic signed [W_WIDTH-1:0]    w_data;
    logic [N_OUT-1:0]             out1;
    logic                         out_valid;
    logic [N_OUT*ACC_WIDTH-1:0]   score;
    logic [15:0]                  n_err;

    modport master (
        output in_valid, letter, learn, target, w_wr, w_i, w_j, w_data,
        input  in_ready, out1, out_valid, score, n_err
    );

    modport slave (
        input  in_valid, letter, learn, target, w_wr, w_i, w_j, w_data,
        output in_ready, out1, out_valid, score, n_err
    );
endinterface

// File: rtl/perceptron_layer_seq.sv
// Single-layer perceptron: one pixel per cycle MAC over all neurons, strict threshold, optional perceptron-rule update.
// Result N_IN+1 edges after accept (2*N_IN+2 to ready when learning); in_ready only in IDLE, requests while busy dropped.
module perceptron_layer_seq #(
    parameter int N_IN      = 20,
    parameter int N_OUT     = 8,
    parameter int W_WIDTH   = 16,
    parameter int ACC_WIDTH = 32,
    parameter int THRESHOLD = 8000,
    parameter int LR        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    perceptron_layer_seq_if.slave bus
);
    localparam int CW    = $clog2(N_IN + 1);
    localparam int W_MAX = (1 << (W_WIDTH - 1)) - 1;
    localparam int W_MIN = -(1 << (W_WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_THRESH, S_UPDATE} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [N_IN-1:0]              letter_q, letter_d;
    logic [N_OUT-1:0]             target_q, target_d;
    logic                         learn_q, learn_d;
    logic [N_OUT-1:0]             out1_q, out1_d;
    logic                         out_valid_q, out_valid_d;
    logic                         in_ready_q, in_ready_d;
    logic [15:0]                  n_err_q, n_err_d;
    logic [N_OUT*ACC_WIDTH-1:0]   score_q, score_d;
    logic signed [ACC_WIDTH-1:0]  acc_q [N_OUT];
    logic signed [ACC_WIDTH-1:0]  acc_d [N_OUT];
    logic signed [W_WIDTH-1:0]    w_q [N_IN][N_OUT];
    logic signed [W_WIDTH-1:0]    w_d [N_IN][N_OUT];
    logic                         accept;
    logic                         w_in_range;

    // One perceptron-rule step, clamped to the signed weight range.
    function automatic logic signed [W_WIDTH-1:0] learn_step(
        input logic signed [W_WIDTH-1:0] w,
        input logic                      t,
        input logic                      o
    );
        logic signed [31:0] s;
        s = 32'(w);
        if (t && !o)      s = s + LR;
        else if (!t && o) s = s - LR;
        if (s > W_MAX)      s = W_MAX;
        else if (s < W_MIN) s = W_MIN;
        return W_WIDTH'(s);
    endfunction

    assign accept     = bus.in_valid && in_ready_q;
    assign w_in_range = (32'(bus.w_i) < N_IN) && (32'(bus.w_j) < N_OUT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        letter_d    = letter_q;
        target_d    = target_q;
        learn_d     = learn_q;
        out1_d      = out1_q;
        out_valid_d = 1'b0;
        n_err_d     = n_err_q;
        score_d     = score_q;
        acc_d       = acc_q;
        w_d         = w_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    letter_d = bus.letter;
                    target_d = bus.target;
                    learn_d  = bus.learn;
                    cnt_d    = '0;
                    for (int j = 0; j < N_OUT; j++) acc_d[j] = '0;
                    state_d  = S_ACCUM;
                end else if (bus.w_wr && w_in_range) begin
                    w_d[bus.w_i][bus.w_j] = bus.w_data;
                end
            end
            S_ACCUM: begin
                if (letter_q[cnt_q]) begin
                    for (int j = 0; j < N_OUT; j++)
                        acc_d[j] = acc_q[j] + ACC_WIDTH'(w_q[cnt_q][j]);
                end
                if (cnt_q == CW'(N_IN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_THRESH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_THRESH: begin
                for (int j = 0; j < N_OUT; j++) begin
                    out1_d[j]                         = acc_q[j] > ACC_WIDTH'(THRESHOLD);
                    score_d[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[j];
                end
                out_valid_d = 1'b1;
                state_d     = learn_q ? S_UPDATE : S_IDLE;
            end
            S_UPDATE: begin
                // First update cycle also books the error; the extra final cycle returns to IDLE.
                if (cnt_q == '0 && out1_q != target_q && n_err_q != 16'hFFFF)
                    n_err_d = n_err_q + 16'd1;
                if (cnt_q == CW'(N_IN)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (letter_q[cnt_q]) begin
                        for (int j = 0; j < N_OUT; j++)
                            w_d[cnt_q][j] = learn_step(w_q[cnt_q][j], target_q[j], out1_q[j]);
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            letter_q    <= '0;
            target_q    <= '0;
            learn_q     <= 1'b0;
            out1_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            n_err_q     <= '0;
            score_q     <= '0;
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
            for (int i = 0; i < N_IN; i++)
                for (int j = 0; j < N_OUT; j++) w_q[i][j] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            letter_q    <= letter_d;
            target_q    <= target_d;
            learn_q     <= learn_d;
            out1_q      <= out1_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            n_err_q     <= n_err_d;
            score_q     <= score_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out1      = out1_q;
    assign bus.out_valid = out_valid_q;
    assign bus.score     = score_q;
    assign bus.n_err     = n_err_q;
endmodule
